// File: rtl/melody_pkg.sv
// Shared constants, FSM state type and slot helpers for the melody recorder
// and the game module that consumes its packed word.
package melody_pkg;

  localparam int NUM_NOTES = 8;
  localparam int SLOT_W    = 4;
  localparam int NOTE_W    = 3;
  localparam int MIN_NOTES = 3;
  localparam int WORD_W    = NUM_NOTES * SLOT_W;

  typedef logic [3:0] count_t;
  typedef logic [3:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_COMMIT = 2'd2,
    ST_START  = 2'd3
  } state_e;

  // Bit offset of slot k inside the packed word.
  function automatic int unsigned slot_lsb(input count_t k);
    return int'(k) * SLOT_W;
  endfunction

  function automatic logic note_valid(input key_t code);
    return (code[3] == 1'b0) && (code[NOTE_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/melody_recorder_if.sv
// Keypad-side inputs and game-side load outputs of the melody recorder.
// MELODY_PREVIEW_EN adds the piezo_out preview signal.
interface melody_recorder_if;
  import melody_pkg::*;

  key_t              keypad_input;
  logic              keypad_enable;
  logic              record_start;
  logic              commit;
  logic [WORD_W-1:0] data_out;
  logic              write_enable;
  logic              game_start;
  count_t            note_count;
  logic              busy;
  logic              error;
`ifdef MELODY_PREVIEW_EN
  logic [3:0]        piezo_out;
`endif

  modport master (
    output keypad_input, keypad_enable, record_start, commit,
    input  data_out, write_enable, game_start, note_count, busy, error
`ifdef MELODY_PREVIEW_EN
    , piezo_out
`endif
  );

  modport slave (
    input  keypad_input, keypad_enable, record_start, commit,
    output data_out, write_enable, game_start, note_count, busy, error
`ifdef MELODY_PREVIEW_EN
    , piezo_out
`endif
  );

endinterface

// File: rtl/key_edge_detect.sv
// Turns the level keypad_enable into a one-cycle press pulse on its rising
// edge and presents the key code sampled in that same cycle.
module key_edge_detect
  import melody_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic key_enable_i,
  input  key_t key_code_i,
  output logic press_o,
  output key_t code_o
);

  logic enable_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_prev_q <= 1'b0;
    end else begin
      enable_prev_q <= key_enable_i;
    end
  end

  assign press_o = key_enable_i & ~enable_prev_q;
  assign code_o  = key_code_i;

endmodule

// File: rtl/melody_recorder.sv
// Records keypad notes into the packed 8x4-bit melody word and loads the game
// module (write_enable, then game_start). MELODY_PREVIEW_EN adds piezo preview.
module melody_recorder #(
  parameter int NUM_NOTES      = melody_pkg::NUM_NOTES,
  parameter int MIN_NOTES      = melody_pkg::MIN_NOTES
`ifdef MELODY_PREVIEW_EN
  , parameter int PREVIEW_CYCLES = 500000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  melody_recorder_if.slave   bus
);
  import melody_pkg::*;

  localparam count_t FULL_CNT = count_t'(NUM_NOTES);
  localparam count_t MIN_CNT  = count_t'(MIN_NOTES);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] data_q, data_d;
  count_t            count_q, count_d;
  logic              error_q, error_d;
  logic              note_accept;
  logic              press;
  key_t              code;

  key_edge_detect u_key_edge (
    .clk          (clk),
    .reset        (reset),
    .key_enable_i (bus.keypad_enable),
    .key_code_i   (bus.keypad_input),
    .press_o      (press),
    .code_o       (code)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    count_d     = count_q;
    error_d     = 1'b0;
    note_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.record_start) begin
          shadow_d = '0;
          count_d  = '0;
          state_d  = ST_RECORD;
        end
      end

      ST_RECORD: begin
        if (bus.record_start) begin
          shadow_d = '0;
          count_d  = '0;
        end else begin
          if (press) begin
            if (!note_valid(code)) begin
              error_d = 1'b1;
            end else if (count_q != FULL_CNT) begin
              shadow_d[slot_lsb(count_q) +: SLOT_W] = {1'b0, code[NOTE_W-1:0]};
              count_d     = count_q + count_t'(1);
              note_accept = 1'b1;
            end
          end

          // Commit checks see the count after a same-cycle press.
          if (count_d == FULL_CNT) begin
            state_d = ST_COMMIT;
          end else if (bus.commit) begin
            if (count_d >= MIN_CNT) state_d = ST_COMMIT;
            else                    error_d = 1'b1;
          end

          if (state_d == ST_COMMIT) data_d = shadow_d;
        end
      end

      ST_COMMIT: state_d = ST_START;
      ST_START:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      data_q   <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.write_enable = (state_q == ST_COMMIT);
  assign bus.game_start   = (state_q == ST_START);
  assign bus.note_count   = count_q;
  assign bus.busy         = (state_q == ST_RECORD) || (state_q == ST_COMMIT);
  assign bus.error        = error_q;

`ifdef MELODY_PREVIEW_EN
  localparam int TMR_W = $clog2(PREVIEW_CYCLES + 1);

  logic [TMR_W-1:0] timer_q;
  logic [3:0]       piezo_q;

  // A new accepted note restarts the tone; the timer counts the remaining
  // cycles after the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      piezo_q <= '0;
    end else if (note_accept) begin
      timer_q <= TMR_W'(PREVIEW_CYCLES - 1);
      piezo_q <= {1'b0, code[NOTE_W-1:0]};
    end else if (timer_q != '0) begin
      timer_q <= timer_q - TMR_W'(1);
    end else begin
      piezo_q <= '0;
    end
  end

  assign bus.piezo_out = piezo_q;
`endif

endmodule

// File: tb/tb_melody_recorder.sv
// Scoreboard bench for melody_recorder: expected words are queued as stimulus
// is driven and popped when write_enable fires.
module tb_melody_recorder;
  import melody_pkg::*;

  localparam int PCY = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   we_seen = 0;
  logic prev_we = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  melody_recorder_if bus();

`ifdef MELODY_PREVIEW_EN
  melody_recorder #(.PREVIEW_CYCLES(PCY)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  melody_recorder dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  // Scoreboard monitor: every load must match the oldest queued word and be
  // followed by exactly one game_start.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (bus.write_enable === 1'b1) begin
        we_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_load: data_out=%h with no expected word", bus.data_out);
        end else begin
          logic [31:0] exp;
          exp = exp_q.pop_front();
          if (bus.data_out !== exp) begin
            errors++;
            $display("FAIL load_word: got %h expected %h", bus.data_out, exp);
          end
        end
      end
      if (prev_we || bus.game_start === 1'b1) begin
        checks++;
        if (bus.game_start !== prev_we) begin
          errors++;
          $display("FAIL game_start_timing: got %b expected %b", bus.game_start, prev_we);
        end
      end
      prev_we = (bus.write_enable === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.record_start = 1'b1;
    tick(1);
    bus.record_start = 1'b0;
  endtask

  task automatic pulse_commit(output logic err_o);
    bus.commit = 1'b1;
    tick(1);
    bus.commit = 1'b0;
    err_o = bus.error;
  endtask

  task automatic press(input key_t code, output logic err_o);
    bus.keypad_input  = code;
    bus.keypad_enable = 1'b1;
    tick(1);
    err_o = bus.error;
    bus.keypad_enable = 1'b0;
    tick(1);
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    bus.keypad_input = '0; bus.keypad_enable = 1'b0;
    bus.record_start = 1'b0; bus.commit = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    expect_val("reset_data_out", bus.data_out, 32'h0);
    expect_val("reset_outputs", {28'h0, bus.write_enable, bus.game_start, bus.busy, bus.error}, 32'h0);
    expect_val("reset_count", {28'h0, bus.note_count}, 32'h0);
  endtask

  task automatic test_basic();
    logic e;
    int   we0;
    we0 = we_seen;
    pulse_start();
    expect_val("busy_in_record", {31'h0, bus.busy}, 32'h1);
    press(4'd3, e); press(4'd5, e); press(4'd7, e);
    expect_val("basic_count", {28'h0, bus.note_count}, 32'd3);
    exp_q.push_back(32'h0000_0753);
    pulse_commit(e);
    expect_val("basic_we_latency", {31'h0, bus.write_enable}, 32'h1);
    expect_val("basic_data_out", bus.data_out, 32'h0000_0753);
    tick(1);
    expect_val("basic_game_start", {30'h0, bus.game_start, bus.write_enable}, 32'h2);
    tick(2);
    expect_val("basic_single_load", we_seen - we0, 1);
    expect_val("basic_idle_busy", {31'h0, bus.busy}, 32'h0);
  endtask

  task automatic test_auto_commit();
    logic e;
    int   we0;
    we0 = we_seen;
    pulse_start();
    for (int i = 1; i <= 7; i++) press(key_t'(i), e);
    exp_q.push_back(32'h2765_4321);
    press(4'd2, e);
    tick(3);
    expect_val("auto_single_load", we_seen - we0, 1);
    expect_val("auto_count", {28'h0, bus.note_count}, 32'd8);
    expect_val("auto_data_held", bus.data_out, 32'h2765_4321);
  endtask

  task automatic test_min_commit();
    logic e;
    int   we0;
    we0 = we_seen;
    pulse_start();
    press(4'd4, e);
    pulse_commit(e);
    expect_val("short_commit_error", {31'h0, e}, 32'h1);
    tick(1);
    expect_val("short_commit_no_load", we_seen - we0, 0);
    expect_val("short_commit_busy", {31'h0, bus.busy, 1'b0} >> 1, 32'h1);
    press(4'd6, e); press(4'd1, e);
    exp_q.push_back(32'h0000_0164);
    pulse_commit(e);
    expect_val("min_commit_no_error", {31'h0, e}, 32'h0);
    tick(3);
    expect_val("min_commit_load", we_seen - we0, 1);
  endtask

  task automatic test_invalid_keys();
    logic e;
    pulse_start();
    press(4'd0, e);
    expect_val("code0_error", {31'h0, e}, 32'h1);
    press(4'd9, e);
    expect_val("code9_error", {31'h0, e}, 32'h1);
    expect_val("invalid_count", {28'h0, bus.note_count}, 32'd0);
    press(4'd5, e);
    expect_val("valid_no_error", {31'h0, e}, 32'h0);
    press(4'd2, e); press(4'd3, e);
    exp_q.push_back(32'h0000_0325);
    pulse_commit(e);
    tick(3);
  endtask

  task automatic test_hold_and_idle();
    logic e;
    int   we0;
    pulse_start();
    bus.keypad_input = 4'd6;
    bus.keypad_enable = 1'b1;
    tick(100);
    bus.keypad_enable = 1'b0;
    tick(1);
    expect_val("hold_one_slot", {28'h0, bus.note_count}, 32'd1);
    press(4'd1, e); press(4'd2, e);
    exp_q.push_back(32'h0000_0216);
    pulse_commit(e);
    tick(3);
    we0 = we_seen;
    press(4'd2, e);
    expect_val("idle_press_no_error", {31'h0, e}, 32'h0);
    tick(2);
    expect_val("idle_press_count", {28'h0, bus.note_count}, 32'd3);
    expect_val("idle_press_no_load", we_seen - we0, 0);
  endtask

  task automatic test_simultaneous();
    logic e;
    int   we0;
    // Press that reaches MIN_NOTES together with commit.
    pulse_start();
    press(4'd1, e); press(4'd2, e);
    exp_q.push_back(32'h0000_0321);
    bus.keypad_input = 4'd3; bus.keypad_enable = 1'b1; bus.commit = 1'b1;
    tick(1);
    bus.keypad_enable = 1'b0; bus.commit = 1'b0;
    expect_val("press_commit_we", {31'h0, bus.write_enable}, 32'h1);
    tick(3);
    // record_start overrides a same-cycle press and commit.
    we0 = we_seen;
    pulse_start();
    press(4'd1, e); press(4'd2, e); press(4'd3, e);
    bus.record_start = 1'b1; bus.commit = 1'b1;
    bus.keypad_input = 4'd4; bus.keypad_enable = 1'b1;
    tick(1);
    bus.record_start = 1'b0; bus.commit = 1'b0; bus.keypad_enable = 1'b0;
    expect_val("restart_priority_count", {28'h0, bus.note_count}, 32'd0);
    tick(2);
    expect_val("restart_priority_no_load", we_seen - we0, 0);
    // Filling the last slot with a same-cycle commit loads once.
    for (int i = 0; i < 7; i++) press(4'd7, e);
    exp_q.push_back(32'h1777_7777);
    bus.keypad_input = 4'd1; bus.keypad_enable = 1'b1; bus.commit = 1'b1;
    tick(1);
    bus.keypad_enable = 1'b0; bus.commit = 1'b0;
    tick(4);
    expect_val("full_commit_single_load", we_seen - we0, 1);
  endtask

  task automatic test_mid_reset();
    logic e;
    int   we0;
    we0 = we_seen;
    pulse_start();
    for (int i = 1; i <= 5; i++) press(key_t'(i), e);
    expect_val("pre_reset_count", {28'h0, bus.note_count}, 32'd5);
    reset = 1'b1;
    #1;
    expect_val("mid_reset_data_out", bus.data_out, 32'h0);
    expect_val("mid_reset_flags", {28'h0, bus.note_count}
               | {28'h0, bus.write_enable, bus.game_start, bus.busy, bus.error}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(3);
    expect_val("mid_reset_no_load", we_seen - we0, 0);
    expect_val("mid_reset_idle", {31'h0, bus.busy}, 32'h0);
  endtask

`ifdef MELODY_PREVIEW_EN
  task automatic test_preview();
    int on_cycles;
    pulse_start();
    bus.keypad_input = 4'd5; bus.keypad_enable = 1'b1;
    tick(1);
    bus.keypad_enable = 1'b0;
    on_cycles = 0;
    for (int i = 0; i < PCY + 10; i++) begin
      if (bus.piezo_out == 4'd5) on_cycles++;
      tick(1);
    end
    expect_val("preview_length", on_cycles, PCY);
    expect_val("preview_off", {28'h0, bus.piezo_out}, 32'h0);
    pulse_start();
    tick(2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_auto_commit();
    test_min_commit();
    test_invalid_keys();
    test_hold_and_idle();
    test_simultaneous();
`ifdef MELODY_PREVIEW_EN
    test_preview();
`endif
    test_mid_reset();
    expect_val("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
